// File: rtl/aes_decipher_block_pkg.sv
// rtl/aes_decipher_block_pkg.sv - shared AES key/round constants, FSM and update encodings, inverse-round GF helpers
package aes_decipher_block_pkg;

  localparam logic       AES_128_BIT_KEY = 1'b0;
  localparam logic       AES_256_BIT_KEY = 1'b1;
  localparam logic [3:0] AES128_ROUNDS   = 4'd10;
  localparam logic [3:0] AES256_ROUNDS   = 4'd14;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_INIT = 2'd1,
    CTRL_SBOX = 2'd2,
    CTRL_MAIN = 2'd3
  } ctrl_state_e;

  typedef enum logic [2:0] {
    UPD_NO    = 3'd0,
    UPD_INIT  = 3'd1,
    UPD_SBOX  = 3'd2,
    UPD_MAIN  = 3'd3,
    UPD_FINAL = 3'd4
  } update_type_e;

  function automatic logic [3:0] num_rounds(input logic keylen);
    return (keylen == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
  endfunction

  function automatic logic [7:0] gm2(input logic [7:0] op);
    return {op[6:0], 1'b0} ^ (8'h1b & {8{op[7]}});
  endfunction

  function automatic logic [7:0] gm4(input logic [7:0] op);
    return gm2(gm2(op));
  endfunction

  function automatic logic [7:0] gm8(input logic [7:0] op);
    return gm2(gm4(op));
  endfunction

  function automatic logic [7:0] gm09(input logic [7:0] op);
    return gm8(op) ^ op;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] op);
    return gm8(op) ^ gm2(op) ^ op;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] op);
    return gm8(op) ^ gm4(op) ^ op;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] op);
    return gm8(op) ^ gm4(op) ^ gm2(op);
  endfunction

  // Byte 0 is the MSB of the column word (row 0).
  function automatic logic [31:0] inv_mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    return {gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm09(b3),
            gm09(b0) ^ gm14(b1) ^ gm11(b2) ^ gm13(b3),
            gm13(b0) ^ gm09(b1) ^ gm14(b2) ^ gm11(b3),
            gm11(b0) ^ gm13(b1) ^ gm09(b2) ^ gm14(b3)};
  endfunction

  function automatic logic [127:0] inv_mixcolumns(input logic [127:0] d);
    return {inv_mixw(d[127:96]), inv_mixw(d[95:64]), inv_mixw(d[63:32]), inv_mixw(d[31:0])};
  endfunction

  function automatic logic [127:0] inv_shiftrows(input logic [127:0] d);
    logic [31:0] w0, w1, w2, w3;
    w0 = d[127:96];
    w1 = d[95:64];
    w2 = d[63:32];
    w3 = d[31:0];
    return {w0[31:24], w3[23:16], w2[15:8], w1[7:0],
            w1[31:24], w0[23:16], w3[15:8], w2[7:0],
            w2[31:24], w1[23:16], w0[15:8], w3[7:0],
            w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
  endfunction

  function automatic logic [127:0] addroundkey(input logic [127:0] d, input logic [127:0] rk);
    return d ^ rk;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// rtl/aes_inv_sbox.sv - combinational inverse S-box over one 32-bit word (four byte lookups)
module aes_inv_sbox (
  input  logic [31:0] in_word,
  output logic [31:0] out_word
);

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] lookup(input logic [7:0] x);
    return INV_SBOX[{~x, 3'b000} +: 8];
  endfunction

  assign out_word = {lookup(in_word[31:24]), lookup(in_word[23:16]),
                     lookup(in_word[15:8]),  lookup(in_word[7:0])};

endmodule

// File: rtl/aes_decipher_block.sv
// rtl/aes_decipher_block.sv - iterative AES-128/256 inverse cipher; AES_DECIPHER_PARALLEL_SBOX_EN selects 4-wide InvSubBytes
module aes_decipher_block
  import aes_decipher_block_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  ctrl_state_e  state_q, state_d;
  update_type_e upd;
  logic [31:0]  w_q [0:3];
  logic [31:0]  w_d [0:3];
  logic [3:0]   w_we;
  logic [1:0]   word_ctr_q, word_ctr_d;
  logic [3:0]   round_ctr_q, round_ctr_d;
  logic         ready_q, ready_d;
  logic         keylen_q, keylen_d;
  logic [127:0] state_blk, blk;
  logic         load_blk;

  assign state_blk = {w_q[0], w_q[1], w_q[2], w_q[3]};
  assign new_block = state_blk;
  assign round     = round_ctr_q;
  assign ready     = ready_q;

`ifdef AES_DECIPHER_PARALLEL_SBOX_EN
  logic [31:0] sbox_out [0:3];
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_inv_sbox u_inv_sbox (.in_word(w_q[i]), .out_word(sbox_out[i]));
  end
`else
  logic [31:0] sbox_out;
  aes_inv_sbox u_inv_sbox (.in_word(w_q[word_ctr_q]), .out_word(sbox_out));
`endif

  always_comb begin
    state_d     = state_q;
    round_ctr_d = round_ctr_q;
    word_ctr_d  = word_ctr_q;
    ready_d     = ready_q;
    keylen_d    = keylen_q;
    upd         = UPD_NO;
    case (state_q)
      CTRL_IDLE: begin
        if (next) begin
          keylen_d    = keylen;
          round_ctr_d = num_rounds(keylen);
          ready_d     = 1'b0;
          state_d     = CTRL_INIT;
        end
      end
      CTRL_INIT: begin
        upd         = UPD_INIT;
        round_ctr_d = num_rounds(keylen_q) - 4'd1;
        word_ctr_d  = 2'd0;
        state_d     = CTRL_SBOX;
      end
      CTRL_SBOX: begin
        upd = UPD_SBOX;
`ifdef AES_DECIPHER_PARALLEL_SBOX_EN
        state_d = CTRL_MAIN;
`else
        word_ctr_d = word_ctr_q + 2'd1;
        if (word_ctr_q == 2'd3) state_d = CTRL_MAIN;
`endif
      end
      CTRL_MAIN: begin
        if (round_ctr_q != 4'd0) begin
          upd         = UPD_MAIN;
          round_ctr_d = round_ctr_q - 4'd1;
          word_ctr_d  = 2'd0;
          state_d     = CTRL_SBOX;
        end else begin
          upd     = UPD_FINAL;
          ready_d = 1'b1;
          state_d = CTRL_IDLE;
        end
      end
      default: state_d = CTRL_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) w_d[i] = w_q[i];
    w_we     = 4'h0;
    blk      = '0;
    load_blk = 1'b0;
    case (upd)
      UPD_INIT: begin
        blk      = inv_shiftrows(addroundkey(block, round_key));
        load_blk = 1'b1;
      end
      UPD_MAIN: begin
        blk      = inv_shiftrows(inv_mixcolumns(addroundkey(state_blk, round_key)));
        load_blk = 1'b1;
      end
      UPD_FINAL: begin
        blk      = addroundkey(state_blk, round_key);
        load_blk = 1'b1;
      end
      UPD_SBOX: begin
`ifdef AES_DECIPHER_PARALLEL_SBOX_EN
        for (int i = 0; i < 4; i++) w_d[i] = sbox_out[i];
        w_we = 4'hf;
`else
        w_d[word_ctr_q]  = sbox_out;
        w_we[word_ctr_q] = 1'b1;
`endif
      end
      default: ;
    endcase
    if (load_blk) begin
      w_d[0] = blk[127:96];
      w_d[1] = blk[95:64];
      w_d[2] = blk[63:32];
      w_d[3] = blk[31:0];
      w_we   = 4'hf;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CTRL_IDLE;
      round_ctr_q <= 4'd0;
      word_ctr_q  <= 2'd0;
      ready_q     <= 1'b1;
      keylen_q    <= 1'b0;
      for (int i = 0; i < 4; i++) w_q[i] <= 32'h0;
    end else begin
      state_q     <= state_d;
      round_ctr_q <= round_ctr_d;
      word_ctr_q  <= word_ctr_d;
      ready_q     <= ready_d;
      keylen_q    <= keylen_d;
      for (int i = 0; i < 4; i++) begin
        if (w_we[i]) w_q[i] <= w_d[i];
      end
    end
  end

endmodule

// File: tb/tb_aes_decipher_block.sv
// tb/tb_aes_decipher_block.sv - scoreboard bench: FIPS-197 vectors, random round trips, busy/abort/back-to-back cases
module tb_aes_decipher_block;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         next = 1'b0;
  logic         keylen = 1'b0;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] block = '0;
  logic [127:0] new_block;
  logic         ready;

  logic [127:0] rk_dut [0:15];
  logic [127:0] rk_model [0:14];
  logic [7:0]   sbox_t [0:255];

  logic [127:0] exp_pt_q [$];
  int           exp_lat_q [$];
  string        exp_tag_q [$];

  int total = 0;
  int bad = 0;
  int mon_low = 0;

`ifdef AES_DECIPHER_PARALLEL_SBOX_EN
  localparam int CYC_PER_ROUND = 2;
`else
  localparam int CYC_PER_ROUND = 5;
`endif

  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3_CT   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] C1_KEY  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] C3_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  assign round_key = rk_dut[round];

  aes_decipher_block dut (
    .clk(clk), .reset_n(reset_n), .next(next), .keylen(keylen), .round(round),
    .round_key(round_key), .block(block), .new_block(new_block), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Reference model: plain FIPS-197 forward cipher on a 16-byte array.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input logic kl);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nk, nr;
    nk = kl ? 8 : 4;
    nr = kl ? 14 : 10;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk_model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encipher(input logic [127:0] pt, input logic kl);
    logic [7:0] s [0:15];
    logic [7:0] ns [0:15];
    logic [127:0] out;
    int nr;
    nr = kl ? 14 : 10;
    for (int k = 0; k < 16; k++) s[k] = pt[127 - 8*k -: 8] ^ rk_model[0][127 - 8*k -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) s[k] = sbox_t[s[k]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) ns[4*c + row] = s[4*((c + row) % 4) + row];
      for (int k = 0; k < 16; k++) s[k] = ns[k];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          ns[4*c]   = gmul(s[4*c], 2) ^ gmul(s[4*c+1], 3) ^ s[4*c+2] ^ s[4*c+3];
          ns[4*c+1] = s[4*c] ^ gmul(s[4*c+1], 2) ^ gmul(s[4*c+2], 3) ^ s[4*c+3];
          ns[4*c+2] = s[4*c] ^ s[4*c+1] ^ gmul(s[4*c+2], 2) ^ gmul(s[4*c+3], 3);
          ns[4*c+3] = gmul(s[4*c], 3) ^ s[4*c+1] ^ s[4*c+2] ^ gmul(s[4*c+3], 2);
        end
        for (int k = 0; k < 16; k++) s[k] = ns[k];
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk_model[r][127 - 8*k -: 8];
    end
    for (int k = 0; k < 16; k++) out[127 - 8*k -: 8] = s[k];
    return out;
  endfunction

  function automatic int exp_latency(input logic kl);
    return 1 + CYC_PER_ROUND * (kl ? 14 : 10);
  endfunction

  task automatic load_rk();
    for (int i = 0; i < 15; i++) rk_dut[i] = rk_model[i];
    rk_dut[15] = '0;
  endtask

  task automatic issue(input logic kl, input logic [127:0] ct, input logic [127:0] pt, input string tag);
    keylen = kl;
    block  = ct;
    next   = 1'b1;
    exp_pt_q.push_back(pt);
    exp_lat_q.push_back(exp_latency(kl));
    exp_tag_q.push_back(tag);
    @(posedge clk); #1;
    next = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!ready && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) begin
      total++;
      bad++;
      $display("FAIL wait_ready: ready=%0b after %0d cycles, required 1", ready, n);
    end
  endtask

  // Monitor: every completed operation is matched against the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_low = 0;
      end else if (!ready) begin
        mon_low++;
      end else if (mon_low > 0) begin
        if (exp_pt_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got %h required no result", new_block);
        end else begin
          check({exp_tag_q[0], "_plaintext"}, new_block, exp_pt_q.pop_front());
          check_int({exp_tag_q[0], "_latency"}, mon_low, exp_lat_q.pop_front());
          void'(exp_tag_q.pop_front());
        end
        mon_low = 0;
      end
    end
  end

  initial begin
    int seq [$];
    int lat;
    logic kl;
    logic [255:0] key;
    logic [127:0] pt, ct;

    for (int i = 0; i < 16; i++) rk_dut[i] = '0;
    init_sbox();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("reset_ready", {127'h0, ready}, 128'h1);
    check("reset_new_block", new_block, 128'h0);
    check_int("reset_round", int'(round), 0);

    expand_key(C1_KEY, 1'b0);
    load_rk();
    issue(1'b0, C1_CT, PT_FIPS, "c1");
    wait_ready(200);

    expand_key(C3_KEY, 1'b1);
    load_rk();
    issue(1'b1, C3_CT, PT_FIPS, "c3");
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ready) break;
      if (seq.size() == 0 || seq[$] != int'(round)) seq.push_back(int'(round));
    end
    @(posedge clk); #1;
    check_int("c3_round_count", seq.size(), 15);
    for (int k = 0; k < seq.size() && k < 15; k++) check_int("c3_round_seq", seq[k], 14 - k);

    // next pulses and keylen toggles while busy must not disturb the run.
    wait_ready(200);
    expand_key(C1_KEY, 1'b0);
    load_rk();
    issue(1'b0, C1_CT, PT_FIPS, "c1_busy");
    lat = exp_latency(1'b0);
    for (int c = 1; c <= lat - 3; c++) begin
      next   = (c == 2 || c == lat / 2 || c == lat - 3);
      keylen = (c >= 2 && c < lat - 3) ? c[0] : 1'b0;
      @(posedge clk); #1;
    end
    next   = 1'b0;
    keylen = 1'b0;
    wait_ready(200);

    issue(1'b0, C1_CT, PT_FIPS, "c1_abort");
    repeat (19) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_ready", {127'h0, ready}, 128'h1);
    check("abort_new_block", new_block, 128'h0);
    check_int("abort_round", int'(round), 0);
    void'(exp_pt_q.pop_back());
    void'(exp_lat_q.pop_back());
    void'(exp_tag_q.pop_back());
    @(posedge clk); #1;
    reset_n = 1'b1;
    issue(1'b0, C1_CT, PT_FIPS, "c1_after_reset");

    // Round trips, each started in the first ready cycle of its predecessor.
    for (int i = 0; i < 1000; i++) begin
      kl  = i[0];
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand_key(key, kl);
      ct = encipher(pt, kl);
      wait_ready(200);
      load_rk();
      issue(kl, ct, pt, "roundtrip");
    end
    wait_ready(200);
    repeat (3) @(negedge clk);
    check_int("pending_results", exp_pt_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
